// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : MEM-stage load/store sequencer with lane steering,
//                   misalignment detection and bus acknowledge timeout.
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_mem_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    input  logic        i_wreg,
    input  logic [4:0]  i_wreg_addr,
    input  logic [31:0] i_wreg_data,
    output logic        o_wreg,
    output logic [4:0]  o_wreg_addr,
    output logic [31:0] o_wreg_data,
    output logic        o_stall,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_sel,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_misalign,
    output logic        o_bus_err
);

    localparam logic [3:0] c_OP_LB  = 4'd1;
    localparam logic [3:0] c_OP_LBU = 4'd2;
    localparam logic [3:0] c_OP_LH  = 4'd3;
    localparam logic [3:0] c_OP_LHU = 4'd4;
    localparam logic [3:0] c_OP_LW  = 4'd5;
    localparam logic [3:0] c_OP_SB  = 4'd6;
    localparam logic [3:0] c_OP_SH  = 4'd7;
    localparam logic [3:0] c_OP_SW  = 4'd8;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUS  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [7:0] c_TMO_LAST = 8'(ACK_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q;
    logic [3:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;
    logic        ok_q;
    logic        bus_req_q, bus_we_q;
    logic [31:0] bus_addr_q, bus_wdata_q;
    logic [3:0]  bus_sel_q;
    logic        misalign_q, bus_err_q;

    logic        is_load, is_store, is_valid;
    logic        sz_byte, sz_half, sz_word;
    logic        misal, start, tmo;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Op decode; codes 9-15 fall out as neither load nor store (NONE)
    always_comb begin
        is_load  = (i_mem_op >= c_OP_LB) && (i_mem_op <= c_OP_LW);
        is_store = (i_mem_op >= c_OP_SB) && (i_mem_op <= c_OP_SW);
        is_valid = is_load || is_store;
        sz_byte  = (i_mem_op == c_OP_LB) || (i_mem_op == c_OP_LBU) || (i_mem_op == c_OP_SB);
        sz_half  = (i_mem_op == c_OP_LH) || (i_mem_op == c_OP_LHU) || (i_mem_op == c_OP_SH);
        sz_word  = (i_mem_op == c_OP_LW) || (i_mem_op == c_OP_SW);
        misal    = (sz_half && i_addr[0]) || (sz_word && (i_addr[1:0] != 2'b00));
        start    = (state_q == c_ST_IDLE) && is_valid && !misal;
        tmo      = (state_q == c_ST_BUS) && !i_bus_ack && (cnt_q == c_TMO_LAST);
    end

    always_comb begin
        sel   = 4'b0000;
        wdata = 32'h0;
        if (sz_byte) begin
            sel = 4'b0001 << i_addr[1:0];
        end else if (sz_half) begin
            sel = i_addr[1] ? 4'b1100 : 4'b0011;
        end else if (sz_word) begin
            sel = 4'b1111;
        end
        if (is_store) begin
            if (sz_byte) begin
                wdata = {4{i_store_data[7:0]}};
            end else if (sz_half) begin
                wdata = {2{i_store_data[15:0]}};
            end else begin
                wdata = i_store_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (start) state_d = c_ST_BUS;
            c_ST_BUS:  if (i_bus_ack || tmo) state_d = c_ST_DONE;
            c_ST_DONE: state_d = c_ST_IDLE;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_ST_IDLE;
            cnt_q       <= 8'd0;
            op_q        <= 4'd0;
            off_q       <= 2'd0;
            rdata_q     <= 32'h0;
            ok_q        <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_sel_q   <= 4'b0000;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= (state_q == c_ST_IDLE) && is_valid && misal;
            bus_err_q  <= tmo;
            if (start) begin
                cnt_q       <= 8'd0;
                op_q        <= i_mem_op;
                off_q       <= i_addr[1:0];
                bus_req_q   <= 1'b1;
                bus_we_q    <= is_store;
                bus_addr_q  <= {i_addr[31:2], 2'b00};
                bus_wdata_q <= wdata;
                bus_sel_q   <= sel;
            end else if (state_q == c_ST_BUS) begin
                if (i_bus_ack || tmo) begin
                    // Ack wins over a coincident timeout
                    rdata_q     <= i_bus_rdata;
                    ok_q        <= i_bus_ack;
                    bus_req_q   <= 1'b0;
                    bus_we_q    <= 1'b0;
                    bus_addr_q  <= 32'h0;
                    bus_wdata_q <= 32'h0;
                    bus_sel_q   <= 4'b0000;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (op_q)
            c_OP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            c_OP_LBU: ld_data = {24'h0, ld_byte};
            c_OP_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            c_OP_LHU: ld_data = {16'h0, ld_half};
            default:  ld_data = rdata_q;
        endcase
    end

    always_comb begin
        o_stall     = 1'b0;
        o_wreg      = 1'b0;
        o_wreg_addr = 5'd0;
        o_wreg_data = 32'h0;
        if (!rst) begin
            case (state_q)
                c_ST_IDLE: begin
                    if (is_valid) begin
                        o_stall = !misal;
                    end else begin
                        o_wreg      = i_wreg;
                        o_wreg_addr = i_wreg_addr;
                        o_wreg_data = i_wreg_data;
                    end
                end
                c_ST_BUS: o_stall = 1'b1;
                c_ST_DONE: begin
                    if (ok_q) begin
                        o_wreg      = i_wreg;
                        o_wreg_addr = i_wreg_addr;
                        o_wreg_data = (op_q <= c_OP_LW) ? ld_data : i_wreg_data;
                    end
                end
                default: o_stall = 1'b0;
            endcase
        end
    end

    assign o_bus_req   = bus_req_q;
    assign o_bus_we    = bus_we_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_wdata = bus_wdata_q;
    assign o_bus_sel   = bus_sel_q;
    assign o_misalign  = misalign_q;
    assign o_bus_err   = bus_err_q;

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter: ACK_TIMEOUT, 16, maximum cycles in BUS awaiting i_bus_ack (range 2..255).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: i_mem_op  in  4  memory op from EX/MEM latch: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE.
REQ-005 SHALL have port: i_addr  in  32  effective byte address.
REQ-006 SHALL have port: i_store_data  in  32  store source register value.
REQ-007 SHALL have ports: i_wreg  in  1; i_wreg_addr  in  5; i_wreg_data  in  32  writeback request from EX.
REQ-008 SHALL have ports: o_wreg  out  1; o_wreg_addr  out  5; o_wreg_data  out  32  writeback request to MEM/WB.
REQ-009 SHALL have port: o_stall  out  1  hold all upstream stages (combinational).
REQ-010 SHALL have ports: o_bus_req, o_bus_we  out  1; o_bus_addr, o_bus_wdata  out  32; o_bus_sel  out  4; all registered.
REQ-011 SHALL have ports: i_bus_ack  in  1; i_bus_rdata  in  32  data bus response.
REQ-012 SHALL have ports: o_misalign, o_bus_err  out  1  single-cycle fault pulses (registered).

Function
REQ-013 SHALL implement FSM states IDLE, BUS, DONE.
REQ-014 SHALL define misaligned as: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; byte ops never misaligned.
REQ-015 IDLE, op NONE: o_wreg/addr/data SHALL equal i_wreg/addr/data combinationally; o_stall=0.
REQ-016 IDLE, op misaligned: no bus access, o_stall=0, o_wreg=0, o_misalign=1 in the following cycle only.
REQ-017 IDLE, op valid and aligned: o_stall=1 and o_wreg=0 same cycle; next edge -> BUS with o_bus_req=1, o_bus_addr={i_addr[31:2],2'b00}, o_bus_we=1 for stores else 0.
REQ-018 Byte lanes little-endian: byte k (=addr[1:0]) on bits 8k+7:8k, sel bit k; halfword at addr[1] uses sel 0011 or 1100; word sel 1111; loads drive the same sel.
REQ-019 Store wdata SHALL be replicated: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d; loads drive wdata 0.
REQ-020 BUS: o_stall=1, o_wreg=0; bus outputs held stable until the edge on which i_bus_ack=1 is sampled.
REQ-021 On ack edge: capture i_bus_rdata, o_bus_req=0 next cycle, -> DONE.
REQ-022 BUS cycle counter SHALL start at 0 on entry and increment each BUS cycle; at count ACK_TIMEOUT-1 without ack: -> DONE, o_bus_err=1 for one cycle, result discarded.
REQ-023 DONE (1 cycle): o_stall=0; load success: o_wreg=i_wreg, o_wreg_addr=i_wreg_addr, o_wreg_data=extracted lane, LB/LH sign-extended, LBU/LHU zero-extended; store success: passthrough as REQ-015; timeout: o_wreg=0. Next edge -> IDLE.
REQ-024 i_bus_ack outside BUS SHALL be ignored; ack and timeout on same edge SHALL count as ack.
REQ-025 Every bus transaction SHALL last at least one req cycle; back-to-back ops incur one IDLE cycle between transactions.

Reset
REQ-026 On rst edge: state IDLE, counter 0, captured data 0, o_bus_req/we 0, o_bus_addr/wdata 0, o_bus_sel 0, o_misalign/o_bus_err 0.
REQ-027 While rst=1: o_stall=0, o_wreg=0, o_wreg_addr=0, o_wreg_data=0 regardless of inputs.
REQ-028 rst during BUS SHALL abandon the transaction with o_bus_req=0 from the next cycle and no writeback or fault pulse.

Verification
REQ-029 NONE op, i_wreg=1, addr 5'd3, data 32'h1234 -> outputs identical same cycle, o_stall=0, bus idle.
REQ-030 LB addr 32'h103, ack after 2 cycles, rdata 32'h80FF_0000 -> bus_addr 32'h100, sel 1000; DONE o_wreg_data 32'hFFFF_FF80; stall high 3 cycles.
REQ-031 SH addr 32'h202, data 32'hAAAA_BEEF, immediate ack -> we=1, sel 1100, wdata 32'hBEEF_BEEF, stall 2 cycles.
REQ-032 LW addr 32'h101 -> no req, o_misalign pulse 1 cycle, o_wreg=0, stall 0.
REQ-033 LHU, ack never asserted, ACK_TIMEOUT=16 -> req high 16 cycles, o_bus_err 1 cycle, o_wreg=0 in DONE, then IDLE.
REQ-034 LW in BUS, rst pulsed 1 cycle -> req=0 next cycle, no writeback, later ack ignored.
